// File: rtl/stream_demux2.sv
// stream_demux2 -- one-input, two-output stream demultiplexer.
// Each accepted upstream beat is routed by in_sel (1 = port A, 0 = port B)
// into a single-entry output register owned by that port, so A and B drain
// independently and a stall on one port never blocks traffic to the other.
// Optional beat counters are built only when STREAM_DEMUX2_STATS_EN is defined;
// otherwise a_count/b_count are tied to zero.
module stream_demux2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] b_data,
  output logic [15:0]       a_count,
  output logic [15:0]       b_count
);

  logic              r_aValid;
  logic [DATA_W-1:0] r_aData;
  logic              r_bValid;
  logic [DATA_W-1:0] r_bData;

  logic w_aFree;
  logic w_bFree;
  logic w_loadA;
  logic w_loadB;

  // A register can take a new beat when it is empty or is being emptied this cycle.
  assign w_aFree  = !r_aValid || a_ready;
  assign w_bFree  = !r_bValid || b_ready;
  assign in_ready = in_sel ? w_aFree : w_bFree;

  // Only the selected register loads; in_sel/in_data are irrelevant without in_valid.
  assign w_loadA = in_valid && in_ready && in_sel;
  assign w_loadB = in_valid && in_ready && !in_sel;

  // Port A output register: a load wins over a drain so back-to-back beats keep valid high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_aValid <= 1'b0;
      r_aData  <= '0;
    end else if (w_loadA) begin
      r_aValid <= 1'b1;
      r_aData  <= in_data;
    end else if (a_ready) begin
      r_aValid <= 1'b0;
    end
  end

  // Port B output register: same load-over-drain rule as port A.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bValid <= 1'b0;
      r_bData  <= '0;
    end else if (w_loadB) begin
      r_bValid <= 1'b1;
      r_bData  <= in_data;
    end else if (b_ready) begin
      r_bValid <= 1'b0;
    end
  end

  assign a_valid = r_aValid;
  assign a_data  = r_aData;
  assign b_valid = r_bValid;
  assign b_data  = r_bData;

`ifdef STREAM_DEMUX2_STATS_EN
  logic [15:0] r_aCount;
  logic [15:0] r_bCount;
  logic        w_aXfer;
  logic        w_bXfer;

  assign w_aXfer = r_aValid && a_ready;
  assign w_bXfer = r_bValid && b_ready;

  // Delivered-beat counters, free-running and wrapping at 16 bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_aCount <= '0;
      r_bCount <= '0;
    end else begin
      if (w_aXfer) begin
        r_aCount <= r_aCount + 16'd1;
      end
      if (w_bXfer) begin
        r_bCount <= r_bCount + 16'd1;
      end
    end
  end

  assign a_count = r_aCount;
  assign b_count = r_bCount;
`else
  assign a_count = '0;
  assign b_count = '0;
`endif

endmodule

// File: doc/stream_demux2.md
STREAM_DEMUX2 -- requirements
Module: stream_demux2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the payload width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream beat valid.
REQ-005 SHALL have port in_ready  output  1  upstream beat accepted when in_valid and in_ready are both high.
REQ-006 SHALL have port in_sel  input  1  route select: 1 routes to port A, 0 routes to port B.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have ports a_valid (output, 1), a_ready (input, 1) and a_data (output, DATA_W) forming downstream stream A.
REQ-009 SHALL have ports b_valid (output, 1), b_ready (input, 1) and b_data (output, DATA_W) forming downstream stream B.
REQ-010 SHALL have ports a_count and b_count, each an output of 16 bits, counting beats delivered on A and B respectively.

Function
REQ-011 SHALL hold one output register (a valid flag plus data) per port, A and B; each output port is driven only from its own register.
REQ-012 SHALL compute in_ready combinationally as (!a_valid || a_ready) when in_sel=1, and as (!b_valid || b_ready) when in_sel=0.
REQ-013 SHALL, when an input beat is accepted, load in_data into the selected register and set its valid flag on the next rising edge, giving a latency of exactly 1 cycle.
REQ-014 SHALL clear a register's valid flag after a downstream transfer (x_valid && x_ready) when no new beat loads that register in the same cycle.
REQ-015 SHALL, when a downstream transfer and a new load hit the same register in the same cycle, keep the valid flag high and take the new data, so that full throughput of 1 beat per cycle is sustained.
REQ-016 SHALL hold x_data and x_valid stable while x_valid=1 and x_ready=0, so that no beat is dropped or duplicated.
REQ-017 SHALL let A and B drain independently, so that a stall on one port never blocks beats routed to the other port.
REQ-018 SHALL preserve beat order within each port; no ordering is guaranteed between A and B.
REQ-019 SHALL leave the unselected register unchanged on any accepted beat.
REQ-020 SHALL ignore in_sel and in_data whenever in_valid=0.
REQ-021 SHALL increment a_count or b_count by 1 on each downstream transfer of the matching port, wrapping from 16'hFFFF to 0.

Reset
REQ-022 SHALL, while resetn=0, force a_valid=0, b_valid=0, a_data=0, b_data=0, a_count=0 and b_count=0 immediately, without waiting for a clock edge.
REQ-023 SHALL, on reset asserted mid-transfer, discard any buffered beats; no beat is delivered after reset.
REQ-024 SHALL resume accepting beats on the first rising edge after resetn deasserts.

Configuration
REQ-025 SHALL implement the beat counters only when the macro STREAM_DEMUX2_STATS_EN is defined, with behaviour as in REQ-021.
REQ-026 SHALL, when STREAM_DEMUX2_STATS_EN is undefined, still provide a_count and b_count but tie both to constant 0 and build no counter logic; data-path behaviour is identical in both builds.

Verification
REQ-027 SHALL cover this scenario: hold resetn=0 -> a_valid=b_valid=0, in_ready=1 for either in_sel, counts=0.
REQ-028 SHALL cover this scenario: in_sel=1, in_data=8'hAA accepted, a_ready=1 -> a_valid=1 with a_data=8'hAA on the next cycle, b_valid stays 0, a_count=1 after the transfer.
REQ-029 SHALL cover this scenario: a_ready=0, beat 8'h11 to A, then 8'h22 to A -> in_ready=0 on the second beat, a_data holds 8'h11; after a_ready=1, 8'h11 then 8'h22 appear in order.
REQ-030 SHALL cover this scenario: a_ready=0 with A full, beats 8'h55 and 8'h66 with in_sel=0, b_ready=1 -> both delivered on B back-to-back with in_ready=1, and A unchanged.
REQ-031 SHALL cover this scenario: 100 random beats, random in_sel and random ready signals -> the per-port sequence matches a scoreboard, with no loss or duplication, and counts equal the per-port totals.
REQ-032 SHALL cover this scenario: pulse resetn low while A and B are both valid -> both valid flags drop asynchronously, and the old data never reappears.
